// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared encodings and constants for the sequential binary-to-packed-BCD converter.
package bin_to_bcd_seq_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] BCD_NINE    = 4'd9;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  // Largest value representable in the given number of BCD digits (10^digits - 1).
  function automatic logic [31:0] maxBcdValue(input int digits);
    logic [31:0] v;
    v = 32'd1;
    for (int i = 0; i < digits; i++) v = v * 32'd10;
    return v - 32'd1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module bcd_add3
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [3:0] digitIn,
  output logic [3:0] digitOut
);

  assign digitOut = (digitIn >= ADD3_THRESH) ? digitIn + 4'd3 : digitIn;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one correct-and-shift step per clock,
// out-of-range inputs saturate to all nines with Ovf set.
//
// Handshake: Start is only sampled while Busy=0 (IDLE or the Done cycle); a
// sampled Start latches BinIn and begins a conversion. Done pulses for one cycle
// and BcdOut/Ovf already carry the new result in that cycle.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [BIN_W-1:0]      BinIn,
  output logic                  Busy,
  output logic                  Done,
  output logic [4*DIGITS-1:0]   BcdOut,
  output logic                  Ovf,
  output logic [1:0]            stateDbg
);

  localparam int          SCR_W = 4 * DIGITS;
  localparam int          CNT_W = $clog2(BIN_W + 1);
  localparam logic [31:0] MAXV  = maxBcdValue(DIGITS);

  logic [1:0]       state;
  logic [BIN_W-1:0] binReg;
  logic [SCR_W-1:0] scratch;
  logic [SCR_W-1:0] corrected;
  logic [SCR_W-1:0] shifted;
  logic [SCR_W-1:0] nines;
  logic [CNT_W-1:0] cnt;
  logic             ovfL;
  logic             lastStep;
  logic             startOvf;

  for (genvar g = 0; g < DIGITS; g++) begin : gen_digit
    bcd_add3 u_add3 (
      .digitIn  (scratch[4*g +: 4]),
      .digitOut (corrected[4*g +: 4])
    );
    assign nines[4*g +: 4] = BCD_NINE;
  end

  // Bits leaving the scratch MSB are dropped; that only happens on overflow.
  assign shifted  = {corrected[SCR_W-2:0], binReg[BIN_W-1]};
  assign lastStep = (cnt == CNT_W'(BIN_W - 1));
  assign startOvf = (32'(BinIn) > MAXV);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      binReg  <= '0;
      scratch <= '0;
      cnt     <= '0;
      ovfL    <= 1'b0;
      BcdOut  <= '0;
      Ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            binReg  <= BinIn;
            scratch <= '0;
            cnt     <= '0;
            ovfL    <= startOvf;
            state   <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          scratch <= shifted;
          binReg  <= {binReg[BIN_W-2:0], 1'b0};
          cnt     <= cnt + CNT_W'(1);
          // Publish on the final step so the result is visible during Done.
          if (lastStep) begin
            state  <= DONE;
            BcdOut <= ovfL ? nines : shifted;
            Ovf    <= ovfL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy     = (state == SHIFT);
  assign Done     = (state == DONE);
  assign stateDbg = state;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and random checks for bin_to_bcd_seq against a divide-by-ten BCD model.
module tb_bin_to_bcd_seq;
  import bin_to_bcd_seq_pkg::*;

  localparam int BIN_W  = 14;
  localparam int DIGITS = 4;
  localparam int LAT    = BIN_W + 1;

  logic              Clk;
  logic              Rst;
  logic              Start;
  logic [BIN_W-1:0]  BinIn;
  logic              Busy;
  logic              Done;
  logic [15:0]       BcdOut;
  logic              Ovf;
  logic [1:0]        stateDbg;

  int total;
  int bad;
  logic [15:0] lastBcd;
  logic        lastOvf;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic [15:0]      expBcd;
    logic             expOvf;
  } vec_t;

  vec_t vecs[8];

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .BinIn    (BinIn),
    .Busy     (Busy),
    .Done     (Done),
    .BcdOut   (BcdOut),
    .Ovf      (Ovf),
    .stateDbg (stateDbg)
  );

  // clock/reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] refBcd(input int v);
    logic [15:0] r;
    int x;
    x = (v > 9999) ? 9999 : v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // driver: one conversion with latency, Busy length and output stability checks
  task automatic runConv(input logic [BIN_W-1:0] v, input logic [15:0] expBcd,
                         input logic expOvf, input string name);
    int busyCnt;
    int doneAt;
    bit overlap;
    bit unstable;
    busyCnt  = 0;
    doneAt   = 0;
    overlap  = 0;
    unstable = 0;
    @(negedge Clk);
    BinIn = v;
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (Busy && Done) overlap = 1;
      if (Busy) busyCnt++;
      if (!Done && (BcdOut !== lastBcd || Ovf !== lastOvf)) unstable = 1;
      if (Done) begin
        doneAt = k;
        break;
      end
      @(posedge Clk); #1;
    end
    chk({name, "_latency"}, doneAt, LAT);
    chk({name, "_busycycles"}, busyCnt, BIN_W);
    chk({name, "_bcd"}, {16'h0, BcdOut}, {16'h0, expBcd});
    chk({name, "_ovf"}, {31'h0, Ovf}, {31'h0, expOvf});
    chk({name, "_nooverlap_stable"}, {30'h0, overlap, unstable}, 32'h0);
    lastBcd = expBcd;
    lastOvf = expOvf;
  endtask

  initial begin
    int doneCnt;
    int doneK[2];
    bit overlap;
    total   = 0;
    bad     = 0;
    Rst     = 1'b1;
    Start   = 1'b0;
    BinIn   = '0;
    lastBcd = '0;
    lastOvf = 1'b0;

    vecs[0] = '{14'd1234,  16'h1234, 1'b0};
    vecs[1] = '{14'd0,     16'h0000, 1'b0};
    vecs[2] = '{14'd9999,  16'h9999, 1'b0};
    vecs[3] = '{14'd5,     16'h0005, 1'b0};
    vecs[4] = '{14'd10000, 16'h9999, 1'b1};
    vecs[5] = '{14'd16383, 16'h9999, 1'b1};
    vecs[6] = '{14'd42,    16'h0042, 1'b0};
    vecs[7] = '{14'd9990,  16'h9990, 1'b0};

    // reset state
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_bcd", {16'h0, BcdOut}, 32'h0);
    chk("reset_ovf_busy_done", {29'h0, Ovf, Busy, Done}, 32'h0);
    chk("reset_state", {30'h0, stateDbg}, {30'h0, IDLE});

    // table-driven directed vectors
    for (int i = 0; i < 8; i++) begin
      repeat (2) @(negedge Clk);
      runConv(vecs[i].bin, vecs[i].expBcd, vecs[i].expOvf, $sformatf("vec%0d", i));
    end

    // Start held high, BinIn changed mid-run, back-to-back restart from Done
    repeat (3) @(negedge Clk);
    BinIn = 14'd1234;
    Start = 1'b1;
    @(posedge Clk); #1;
    doneCnt = 0;
    overlap = 0;
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h0007);
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) BinIn = 14'd7;
      if (Busy && Done) overlap = 1;
      if (Done) begin
        doneK[doneCnt] = k;
        chk($sformatf("b2b_bcd%0d", doneCnt), {16'h0, BcdOut}, {16'h0, exp_q.pop_front()});
        doneCnt++;
        if (doneCnt == 2) begin
          Start = 1'b0;
          break;
        end
      end
      @(posedge Clk); #1;
    end
    Start = 1'b0;
    chk("b2b_done_count", doneCnt, 2);
    if (doneCnt == 2) begin
      chk("b2b_first_at", doneK[0], LAT);
      chk("b2b_period", doneK[1] - doneK[0], LAT);
    end
    chk("b2b_overlap", {31'h0, overlap}, 32'h0);
    lastBcd = 16'h0007;
    lastOvf = 1'b0;

    // reset during SHIFT step 7 aborts without Done
    repeat (2) @(negedge Clk);
    BinIn = 14'd4321;
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (6) begin
      @(posedge Clk); #1;
    end
    chk("abort_busy_before", {31'h0, Busy}, 32'h1);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("abort_bcd", {16'h0, BcdOut}, 32'h0);
    chk("abort_ovf_busy_done", {29'h0, Ovf, Busy, Done}, 32'h0);
    doneCnt = 0;
    repeat (20) begin
      @(posedge Clk); #1;
      if (Done) doneCnt++;
    end
    chk("abort_no_done", doneCnt, 0);
    lastBcd = '0;
    lastOvf = 1'b0;
    runConv(14'd4321, 16'h4321, 1'b0, "after_abort");

    // random values with random Start gaps
    for (int n = 0; n < 2000; n++) begin
      int v;
      int gap;
      v   = int'($urandom_range(0, 16383));
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge Clk);
      runConv(14'(v), refBcd(v), (v > 9999), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
